// File: rtl/uart_rx_fifo.sv
// UART receiver with two-flop rx synchroniser, mid-bit sampling deframer and a
// first-word-fall-through FIFO drained over valid/ready, plus sticky error flags.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk_50,
  input  logic                          reset,
  input  logic                          arduino_input,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_error,
  output logic                          parity_error,
  output logic                          overrun,
  input  logic                          err_clear,
  output logic [2:0]                    state_dbg
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_MAX = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  // Encodings are fixed so the state can be observed on state_dbg.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 parity_bit;

  logic                 parity_ok;
  logic                 stop_sample;
  logic                 push_req;
  logic                 push;
  logic                 pop;
  logic                 full;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;

  assign state_dbg = state;

  always_ff @(posedge clk_50) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= arduino_input;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (clk_cnt == HALF_MAX) begin
            clk_cnt <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == CNT_MAX) begin
            clk_cnt        <= '0;
            shift[bit_cnt] <= rx_s;
            if (bit_cnt == LAST_BIT) begin
              state <= (PARITY_MODE != 0) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (clk_cnt == CNT_MAX) begin
            clk_cnt    <= '0;
            parity_bit <= rx_s;
            state      <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          // Leave at mid stop bit so a following start edge is not missed.
          if (clk_cnt == CNT_MAX) begin
            clk_cnt <= '0;
            state   <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    parity_ok = 1'b1;
    if (PARITY_MODE == 1)      parity_ok = (parity_bit == ^shift);
    else if (PARITY_MODE == 2) parity_ok = (parity_bit == ~^shift);
  end

  assign stop_sample = (state == STOP) && (clk_cnt == CNT_MAX);
  assign push_req    = stop_sample && rx_s && parity_ok;

  // Valid/ready: a byte transfers on each cycle where rx_valid && rx_ready;
  // rx_data holds the head byte while rx_valid is high and is zero otherwise.
  assign full     = (fifo_count == FULL_CNT);
  assign rx_valid = (fifo_count != '0);
  assign pop      = rx_valid && rx_ready;
  assign push     = push_req && (!full || pop);
  assign rx_data  = rx_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk_50) begin
    if (push) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // A new event wins over err_clear in the same cycle.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      frame_error  <= 1'b0;
      parity_error <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      frame_error  <= (frame_error  && !err_clear) || (stop_sample && !rx_s);
      parity_error <= (parity_error && !err_clear) || (stop_sample && rx_s && !parity_ok);
      overrun      <= (overrun      && !err_clear) || (push_req && full && !pop);
    end
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver for the Arduino/GUI command link. It synchronises the serial rx line and deframes start/data/parity/stop bits with mid-bit sampling. Good bytes are pushed into a first-word-fall-through FIFO, and the FIFO drains to the command decoder over a valid/ready handshake. Framing, parity and overrun conditions are reported as sticky error flags.

Parameters:
CLKS_PER_BIT, 434, clk_50 cycles per bit (50 MHz / 115200); must be >= 4
DATA_BITS, 8, data bits per frame, 5..9, sent LSB first
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
FIFO_DEPTH, 8, number of FIFO entries; power of two, >= 2

Ports:
clk_50  input  1  system clock; all logic is on its rising edge
reset  input  1  synchronous, active-high reset
arduino_input  input  1  asynchronous serial rx line; idle high
rx_data  output  DATA_BITS  FIFO head byte; valid only while rx_valid = 1
rx_valid  output  1  FIFO is non-empty
rx_ready  input  1  consumer accepts the head byte on a cycle where rx_valid && rx_ready
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
frame_error  output  1  sticky: a stop bit was sampled low
parity_error  output  1  sticky: received parity did not match
overrun  output  1  sticky: a good byte arrived while the FIFO was full
err_clear  input  1  one-cycle pulse; clears all three sticky flags

Behaviour:
- Reset:
  - Clock and reset are fixed: one clock, clk_50; reset is synchronous and active-high.
  - Both synchroniser flops reset to 1. FSM goes to IDLE with counters at 0.
  - FIFO is emptied: rx_valid = 0, fifo_count = 0, rx_data = 0.
  - All error flags reset to 0.
  - Reset asserted mid-frame abandons the frame; no partial byte is ever pushed.
- Synchroniser: two flops; rx_s is the second flop output.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx_s = 0 -> START with the bit counter cleared.
  - START: count CLKS_PER_BIT/2 - 1 cycles, then sample. If rx_s = 1 (glitch), return to IDLE with no error. If rx_s = 0, clear the counter and go to DATA.
  - DATA: sample each time the counter reaches CLKS_PER_BIT - 1, then clear it. Sample k is written to shift bit k (LSB first). After DATA_BITS samples, go to PARITY if PARITY_MODE != 0, else to STOP.
  - PARITY: sample one bit. Expected value = XOR of the data bits for even, inverted XOR for odd.
  - STOP: sample at CLKS_PER_BIT - 1, then go to IDLE on the next cycle. The FSM deliberately leaves half a bit early, so back-to-back frames with one stop bit are received.
- Stop-sample outcome:
  - stop = 0: set frame_error; discard the byte.
  - stop = 1 and parity mismatch: set parity_error; discard the byte.
  - stop = 1 and parity good (or no parity): push the byte.
  - Push while the FIFO is full and no pop in the same cycle: drop the new byte, set overrun, leave FIFO contents unchanged.
  - Push and pop in the same cycle while full: both succeed; count stays at FIFO_DEPTH.
- FIFO (first-word fall-through):
  - A push into an empty FIFO makes rx_valid = 1 and drives rx_data with the byte on the cycle after the stop-sample edge.
  - Pop occurs when rx_valid && rx_ready; rx_data advances on the next cycle.
  - rx_ready while empty has no effect; fifo_count never underflows.
  - Simultaneous push and pop while non-empty: count unchanged, order preserved.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Sticky flags: set on their event and held until err_clear or reset. If err_clear and a new error event occur in the same cycle, the flag ends up set.
- Receive is never stalled by rx_ready; the only back-pressure effect is overrun.

Test Plan:
- CLKS_PER_BIT = 16, PARITY_MODE = 0, rx_ready = 1; send 0xA5 -> rx_valid rises one cycle after the stop sample, rx_data = 0xA5, fifo_count returns to 0 after one cycle, no flags set.
- rx_ready = 0; send 0x01..0x09 back-to-back with FIFO_DEPTH = 8 -> fifo_count = 8, overrun = 1; then pop 8 times -> rx_data sequence 0x01..0x08 (0x09 is lost).
- PARITY_MODE = 1; send 0x03 with parity bit = 1 (wrong) -> parity_error = 1, FIFO stays empty. Then send 0x03 with parity bit = 0 -> 0x03 is delivered.
- Send 0x55 with the stop bit held low -> frame_error = 1, no push. Pulse err_clear -> frame_error = 0.
- Low glitch of 4 cycles on an idle line -> FSM returns to IDLE, no push, no flag set. Assert reset during the DATA bits of a frame -> FIFO empty and no byte delivered after release.
- FIFO full with rx_ready = 1 held while a new good byte completes -> push and pop in the same cycle, fifo_count stays 8, overrun stays 0.
